ramdp_bist: RTL and testbench

//  March C- built-in self-test engine for the single-clock dual-port RAM (ramdp).

---
 rtl/ramdp_bist_if.sv | 14 +
 rtl/ramdp_bist.sv | 181 ++++++++++++++++++
 tb/tb_ramdp_bist.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ramdp_bist_if.sv
// RAM port bundle between the BIST engine and one read/write port of ramdp.
interface ramdp_bist_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 10
);
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (output mem_en, mem_we, mem_addr, mem_din, input mem_dout);
    modport slave  (input mem_en, mem_we, mem_addr, mem_din, output mem_dout);
endinterface

// File: rtl/ramdp_bist.sv
// March C- self-test engine for one ramdp port; a passing run leaves every word at zero.
module ramdp_bist #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [AW-1:0] fail_addr,
    output logic [2:0]    fail_elem,
    ramdp_bist_if.master  mem
);
    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
    localparam logic [DW-1:0] ONES     = {DW{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    elem_q, elem_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;
    logic          en_q, en_d, we_q, we_d;
    logic [DW-1:0] din_q, din_d;
    logic          busy_d, done_d, fail_d;
    logic [AW-1:0] fail_addr_d;
    logic [2:0]    fail_elem_d;
    logic          rd_v_q, rd_v_d, exp_one_q, exp_one_d;
    logic [AW-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]    cmp_elem_q, cmp_elem_d;

    logic          mismatch_c, last_c, two_op_c, down_c, n_phase_c;
    logic [2:0]    n_elem_c;
    logic [AW-1:0] n_addr_c;

    function automatic logic op_we(input logic [2:0] e, input logic p);
        return (e == 3'd0) || ((e != 3'd5) && p);
    endfunction

    assign mem.mem_en   = en_q;
    assign mem.mem_we   = we_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_din  = din_q;

    // Next-op sequencing, pipelined read compare and FSM.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        en_d        = 1'b0;
        we_d        = 1'b0;
        din_d       = '0;
        busy_d      = busy_q_w();
        done_d      = 1'b0;
        fail_d      = fail;
        fail_addr_d = fail_addr;
        fail_elem_d = fail_elem;
        rd_v_d      = en_q & ~we_q;
        exp_one_d   = (elem_q == 3'd2) || (elem_q == 3'd4);
        cmp_addr_d  = addr_q;
        cmp_elem_d  = elem_q;

        mismatch_c = rd_v_q && (mem.mem_dout != (exp_one_q ? ONES : '0));

        two_op_c  = (elem_q != 3'd0) && (elem_q != 3'd5);
        down_c    = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_c    = 1'b0;
        n_elem_c  = elem_q;
        n_addr_c  = addr_q;
        n_phase_c = 1'b0;
        if (two_op_c && !phase_q) begin
            n_phase_c = 1'b1;
        end else if (down_c ? (addr_q == '0) : (addr_q == ADDR_MAX)) begin
            // Element boundary: reload the address rather than relying on wrap.
            if (elem_q == 3'd5) begin
                last_c = 1'b1;
            end else begin
                n_elem_c = elem_q + 3'd1;
                n_addr_c = ((n_elem_c == 3'd3) || (n_elem_c == 3'd4)) ? ADDR_MAX : '0;
            end
        end else begin
            n_addr_c = down_c ? (addr_q - AW'(1)) : (addr_q + AW'(1));
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    busy_d      = 1'b1;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    en_d        = 1'b1;
                    we_d        = 1'b1;
                end
            end
            RUN: begin
                if (mismatch_c) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    fail_d      = 1'b1;
                    fail_addr_d = cmp_addr_q;
                    fail_elem_d = cmp_elem_q;
                end else if (last_c) begin
                    state_d = DRAIN;
                end else begin
                    elem_d  = n_elem_c;
                    addr_d  = n_addr_c;
                    phase_d = n_phase_c;
                    en_d    = 1'b1;
                    we_d    = op_we(n_elem_c, n_phase_c);
                    if (op_we(n_elem_c, n_phase_c) && ((n_elem_c == 3'd1) || (n_elem_c == 3'd3)))
                        din_d = ONES;
                end
            end
            DRAIN: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (mismatch_c) begin
                    fail_d      = 1'b1;
                    fail_addr_d = cmp_addr_q;
                    fail_elem_d = cmp_elem_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    function automatic logic busy_q_w();
        return busy;
    endfunction

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            elem_q     <= 3'd0;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            din_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= 3'd0;
            rd_v_q     <= 1'b0;
            exp_one_q  <= 1'b0;
            cmp_addr_q <= '0;
            cmp_elem_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            en_q       <= en_d;
            we_q       <= we_d;
            din_q      <= din_d;
            busy       <= busy_d;
            done       <= done_d;
            fail       <= fail_d;
            fail_addr  <= fail_addr_d;
            fail_elem  <= fail_elem_d;
            rd_v_q     <= rd_v_d;
            exp_one_q  <= exp_one_d;
            cmp_addr_q <= cmp_addr_d;
            cmp_elem_q <= cmp_elem_d;
        end
    end
endmodule

// File: tb/tb_ramdp_bist.sv
// Directed bench for ramdp_bist: an AW=3/DW=16 instance with fault-injectable RAM model and an AW=1/DW=1 corner instance.
module tb_ramdp_bist;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic sel = 1'b0;
    int   fault = 0;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    ramdp_bist_if #(.DW(16), .AW(3)) ifa ();
    ramdp_bist_if #(.DW(1),  .AW(1)) ifb ();

    logic       busy_a, done_a, fail_a, busy_b, done_b, fail_b;
    logic [2:0] fail_addr_a, fail_elem_a, fail_elem_b;
    logic [0:0] fail_addr_b;

    ramdp_bist #(.DW(16), .AW(3)) u_a (
        .clk(clk), .nreset(nreset), .start(start_a), .busy(busy_a), .done(done_a),
        .fail(fail_a), .fail_addr(fail_addr_a), .fail_elem(fail_elem_a), .mem(ifa));
    ramdp_bist #(.DW(1), .AW(1)) u_b (
        .clk(clk), .nreset(nreset), .start(start_b), .busy(busy_b), .done(done_b),
        .fail(fail_b), .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .mem(ifb));

    // RAM models with registered read; faults applied on the read path.
    logic [15:0] mem_a [8];
    logic [0:0]  mem_b [2];
    logic [15:0] rd_a;
    always_comb begin
        rd_a = mem_a[ifa.mem_addr];
        if (fault == 1 && ifa.mem_addr == 3'd6) rd_a[5] = 1'b1;
        if (fault == 2 && ifa.mem_addr == 3'd2) rd_a[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (ifa.mem_en) begin
            if (ifa.mem_we) mem_a[ifa.mem_addr] <= ifa.mem_din;
            ifa.mem_dout <= rd_a;
        end
        if (ifb.mem_en) begin
            if (ifb.mem_we) mem_b[ifb.mem_addr] <= ifb.mem_din;
            ifb.mem_dout <= mem_b[ifb.mem_addr];
        end
    end

    logic        en_o, we_o, busy_o, done_o, fail_o;
    logic [2:0]  addr_o, faddr_o, felem_o;
    logic [15:0] din_o;
    always_comb begin
        en_o    = sel ? ifb.mem_en : ifa.mem_en;
        we_o    = sel ? ifb.mem_we : ifa.mem_we;
        addr_o  = sel ? {2'b00, ifb.mem_addr} : ifa.mem_addr;
        din_o   = sel ? {15'd0, ifb.mem_din} : ifa.mem_din;
        busy_o  = sel ? busy_b : busy_a;
        done_o  = sel ? done_b : done_a;
        fail_o  = sel ? fail_b : fail_a;
        faddr_o = sel ? {2'b00, fail_addr_b} : fail_addr_a;
        felem_o = sel ? fail_elem_b : fail_elem_a;
    end

    int          en_cnt, wr_cnt, done_at;
    logic        fail_at_done, busy_at_done;
    logic [2:0]  addr_tr [128];
    logic        we_tr [128];
    logic [15:0] din_tr [128];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    // Issue a one-cycle start; returns at the falling edge after E_0.
    task automatic launch();
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
    endtask

    // Observe cycles i = 0.. after E_0 until done (bounded); optional start pulse at pulse_at.
    task automatic track(input int limit, input int pulse_at);
        en_cnt = 0; wr_cnt = 0; done_at = -1; fail_at_done = 1'bx; busy_at_done = 1'bx;
        for (int i = 0; i < limit; i++) begin
            if (en_o) begin
                en_cnt++;
                if (we_o) wr_cnt++;
            end
            if (i < 128) begin
                addr_tr[i] = addr_o; we_tr[i] = we_o; din_tr[i] = din_o;
            end
            if (done_o) begin
                done_at = i; fail_at_done = fail_o; busy_at_done = busy_o;
                break;
            end
            set_start(i == pulse_at);
            @(negedge clk);
        end
        set_start(1'b0);
    endtask

    initial begin
        int         dones, busy_seen;
        logic       nz;
        logic [31:0] av, wv;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({busy_a, done_a, fail_a, ifa.mem_en, ifa.mem_we}), 32'd0);
        chk("reset_fail_info", 32'({fail_addr_a, fail_elem_a, ifa.mem_addr, ifa.mem_din}), 32'd0);
        nreset = 1'b1;

        // Clean run, AW=3.
        launch();
        chk("busy_at_e0", 32'(busy_o), 32'd1);
        track(120, -1);
        chk("clean_en_cycles", 32'(en_cnt), 32'd80);
        chk("clean_writes", 32'(wr_cnt), 32'd40);
        chk("clean_done_at", 32'(done_at), 32'd81);
        chk("clean_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("clean_fail", 32'(fail_at_done), 32'd0);
        chk("e3_start_addr", 32'(addr_tr[40]), 32'd7);
        chk("e4_start_addr", 32'(addr_tr[56]), 32'd7);
        chk("e5_start_addr", 32'(addr_tr[72]), 32'd0);
        chk("last_op_addr", 32'(addr_tr[79]), 32'd7);
        chk("read_din_zero", 32'(din_tr[8]), 32'd0);
        chk("w1_din_ones", 32'(din_tr[9]), 32'h0000_ffff);
        nz = 1'b0;
        for (int w = 0; w < 8; w++) if (mem_a[w] !== 16'd0) nz = 1'b1;
        chk("clean_ram_zero", 32'(nz), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_o), 32'd0);

        // Word 6 bit 5 stuck-at-1: caught by E1 r0 at op 20.
        fault = 1;
        launch();
        track(120, -1);
        chk("sa1_done_at", 32'(done_at), 32'd22);
        chk("sa1_en_cycles", 32'(en_cnt), 32'd22);
        chk("sa1_fail", 32'(fail_at_done), 32'd1);
        repeat (5) @(negedge clk);
        chk("sa1_fail_held", 32'(fail_o), 32'd1);
        chk("sa1_fail_addr", 32'(faddr_o), 32'd6);
        chk("sa1_fail_elem", 32'(felem_o), 32'd1);

        // Word 2 bit 0 stuck-at-0: caught by E2 r1 at op 28.
        fault = 2;
        launch();
        chk("start_clears_fail", 32'(fail_o), 32'd0);
        track(120, -1);
        chk("sa0_done_at", 32'(done_at), 32'd30);
        chk("sa0_fail", 32'(fail_at_done), 32'd1);
        chk("sa0_fail_addr", 32'(faddr_o), 32'd2);
        chk("sa0_fail_elem", 32'(felem_o), 32'd2);

        // Start held high: re-accepted only after each done.
        fault = 0;
        dones = 0;
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_o) dones++;
            if (c == 82) chk("held_idle_gap", 32'(busy_o), 32'd0);
            if (c == 83) chk("held_reaccept", 32'(busy_o), 32'd1);
        end
        chk("held_done_count", 32'(dones), 32'd2);
        start_a = 1'b0;
        @(negedge clk);
        track(120, -1);
        chk("held_third_done_at", 32'(done_at), 32'd47);

        // Start pulsed mid-run is ignored.
        launch();
        track(120, 40);
        chk("pulse_done_at", 32'(done_at), 32'd81);
        busy_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy_o) busy_seen++;
        end
        chk("pulse_not_queued", 32'(busy_seen), 32'd0);

        // Reset at op 37 aborts; then a clean full run.
        launch();
        repeat (37) @(negedge clk);
        chk("op37_running", 32'(en_o), 32'd1);
        #2 nreset = 1'b0;
        #1 chk("abort_outputs", 32'({busy_o, done_o, fail_o, en_o, we_o}), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        launch();
        track(120, -1);
        chk("post_reset_en", 32'(en_cnt), 32'd80);
        chk("post_reset_done_at", 32'(done_at), 32'd81);
        chk("post_reset_fail", 32'(fail_at_done), 32'd0);

        // AW=1, DW=1 corner.
        sel = 1'b1;
        launch();
        track(60, -1);
        chk("aw1_en_cycles", 32'(en_cnt), 32'd20);
        chk("aw1_done_at", 32'(done_at), 32'd21);
        chk("aw1_fail", 32'(fail_at_done), 32'd0);
        av = 32'd0; wv = 32'd0;
        for (int i = 0; i < 20; i++) begin
            av[i] = addr_tr[i][0];
            wv[i] = we_tr[i];
        end
        chk("aw1_addr_order", av, 32'h0008_cf32);
        chk("aw1_we_order", wv, 32'h0002_aaab);
        chk("aw1_ram_zero", 32'({mem_b[1], mem_b[0]}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
